gesture_vector_sequencer: RTL and testbench

- Upstream feeder for the gesture similarity stage.
- Captures one frame of N_VEC signed motion vectors from the optical-flow front end and holds the N_VEC*N_TMPL-entry gesture library in on-chip RAM.
- Replays the captured frame once against every template as one contiguous valid burst: per beat one vector pair, one library pair and a running index.
- Ping-pong frame buffers let the next frame be captured while the current one streams.

---
 rtl/gesture_vector_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_gesture_vector_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_vector_sequencer.sv
// Captures one frame of signed motion vectors into ping-pong banks and replays it
// against every library template as one contiguous beat burst.
module gesture_vector_sequencer #(
  parameter int N_VEC  = 16,
  parameter int N_TMPL = 26,
  parameter int W      = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  input  logic         i_in_sof,
  input  logic [W-1:0] i_in_x,
  input  logic [W-1:0] i_in_y,
  input  logic         i_lib_we,
  input  logic [8:0]   i_lib_addr,
  input  logic [W-1:0] i_lib_x,
  input  logic [W-1:0] i_lib_y,
  output logic         o_valid,
  output logic [8:0]   o_index,
  output logic [W-1:0] o_vector_x,
  output logic [W-1:0] o_vector_y,
  output logic [W-1:0] o_lib_x,
  output logic [W-1:0] o_lib_y,
  output logic         o_busy,
  output logic         o_drop
);
  // Handshake: no back-pressure anywhere. i_in_valid qualifies each input beat and
  // o_valid qualifies each output beat; a started burst never stalls.

  localparam int N_ENT = N_VEC * N_TMPL;
  localparam int SW    = $clog2(N_VEC);
  localparam int AW    = 9;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_GAP = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic            r_gap, w_gap_nxt;
  logic            r_str_bank;

  logic [1:0]      r_full, w_full_nxt;
  logic            r_oldest;
  logic            r_cap_bank;
  logic            r_cap_active;
  logic [SW-1:0]   r_slot;
  logic            r_drop;

  logic [1:0]      w_str_busy, w_free;
  logic            w_sof, w_sof_ok, w_sof_bank, w_mid_beat, w_complete;
  logic            w_cap_we, w_cap_bank;
  logic [SW-1:0]   w_cap_slot;
  logic            w_any_full, w_pend_sel, w_start_sel;
  logic            w_start, w_rd_en, w_rd_bank, w_take_full;
  logic [AW-1:0]   w_rd_addr;

  logic [2*W-1:0]  r_lib_mem [N_ENT];
  logic [2*W-1:0]  r_vec_mem [2*N_VEC];
  logic [2*W-1:0]  r_lib_rd, r_vec_rd;

  logic            r_p1_valid;
  logic [AW-1:0]   r_p1_index;
  logic            r_valid, r_busy;
  logic [AW-1:0]   r_index;
  logic [W-1:0]    r_vx, r_vy, r_lx, r_ly;

  // A bank is free when it holds no pending frame and is not being replayed.
  assign w_str_busy = (r_state == S_STREAM) ? (r_str_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_free     = ~r_full & ~w_str_busy;

  assign w_sof      = i_in_valid & i_in_sof;
  assign w_sof_ok   = w_free[r_cap_bank] | w_free[~r_cap_bank];
  assign w_sof_bank = w_free[r_cap_bank] ? r_cap_bank : ~r_cap_bank;
  assign w_mid_beat = i_in_valid & ~i_in_sof & r_cap_active;
  assign w_complete = w_mid_beat & (r_slot == SW'(N_VEC - 1));
  assign w_cap_we   = (w_sof & w_sof_ok) | w_mid_beat;
  assign w_cap_bank = w_sof ? w_sof_bank : r_cap_bank;
  assign w_cap_slot = w_sof ? '0 : r_slot;

  assign w_any_full  = |r_full;
  assign w_pend_sel  = (&r_full) ? r_oldest : r_full[1];
  assign w_start_sel = w_any_full ? w_pend_sel : r_cap_bank;

  // Stream FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_gap      <= 1'b0;
      r_str_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_gap   <= w_gap_nxt;
      if (w_start) r_str_bank <= w_start_sel;
    end
  end

  // Stream FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (w_any_full || w_complete) begin
          w_state_nxt = S_STREAM;
          w_addr_nxt  = AW'(1);
        end
      end
      S_STREAM: begin
        if (r_addr == AW'(N_ENT - 1)) begin
          w_state_nxt = S_GAP;
          w_addr_nxt  = '0;
          w_gap_nxt   = 1'b0;
        end else begin
          w_addr_nxt = r_addr + AW'(1);
        end
      end
      S_GAP: begin
        if (r_gap) w_state_nxt = S_IDLE;
        else       w_gap_nxt   = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stream FSM: outputs. Address 0 is issued in the cycle the burst starts,
  // which lets a frame's final capture beat launch its own replay.
  always_comb begin
    w_start     = (r_state == S_IDLE) && (w_any_full || w_complete);
    w_rd_en     = w_start || (r_state == S_STREAM);
    w_rd_addr   = (r_state == S_STREAM) ? r_addr : '0;
    w_rd_bank   = (r_state == S_STREAM) ? r_str_bank : w_start_sel;
    w_take_full = w_start && w_any_full;
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_take_full) w_full_nxt[w_pend_sel] = 1'b0;
    if (w_complete && (w_any_full || (r_state != S_IDLE))) w_full_nxt[r_cap_bank] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full       <= 2'b00;
      r_oldest     <= 1'b0;
      r_cap_bank   <= 1'b0;
      r_cap_active <= 1'b0;
      r_slot       <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_drop <= w_sof & ~w_sof_ok;
      if (w_complete && !r_full[~r_cap_bank]) r_oldest <= r_cap_bank;
      if (w_sof) begin
        // No free bank: discard everything up to the next sof.
        if (w_sof_ok) begin
          r_cap_active <= 1'b1;
          r_slot       <= SW'(1);
          r_cap_bank   <= w_sof_bank;
        end else begin
          r_cap_active <= 1'b0;
        end
      end else if (w_mid_beat) begin
        if (w_complete) begin
          r_cap_active <= 1'b0;
          r_slot       <= '0;
          r_cap_bank   <= ~r_cap_bank;
        end else begin
          r_slot <= r_slot + SW'(1);
        end
      end
    end
  end

  // Library RAM: read-before-write, so a same-address write returns old data.
  always_ff @(posedge i_clk) begin
    if (i_lib_we && (i_lib_addr < AW'(N_ENT))) r_lib_mem[i_lib_addr] <= {i_lib_x, i_lib_y};
    if (w_rd_en) r_lib_rd <= r_lib_mem[w_rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (w_cap_we) r_vec_mem[{w_cap_bank, w_cap_slot}] <= {i_in_x, i_in_y};
    if (w_rd_en)  r_vec_rd <= r_vec_mem[{w_rd_bank, w_rd_addr[SW-1:0]}];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p1_valid <= 1'b0;
      r_p1_index <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_index    <= '0;
      r_vx       <= '0;
      r_vy       <= '0;
      r_lx       <= '0;
      r_ly       <= '0;
    end else begin
      r_p1_valid <= w_rd_en;
      r_p1_index <= w_rd_addr;
      r_valid    <= r_p1_valid;
      r_busy     <= (w_state_nxt != S_IDLE) || (|w_full_nxt);
      if (r_p1_valid) begin
        r_index <= r_p1_index;
        r_vx    <= r_vec_rd[2*W-1:W];
        r_vy    <= r_vec_rd[W-1:0];
        r_lx    <= r_lib_rd[2*W-1:W];
        r_ly    <= r_lib_rd[W-1:0];
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_index    = r_index;
  assign o_vector_x = r_vx;
  assign o_vector_y = r_vy;
  assign o_lib_x    = r_lx;
  assign o_lib_y    = r_ly;
  assign o_busy     = r_busy;
  assign o_drop     = r_drop;

endmodule

// File: tb/tb_gesture_vector_sequencer.sv
// Bench for gesture_vector_sequencer: random frames and library data checked
// against a frame/library model that predicts every burst beat and its cycle.
module tb_gesture_vector_sequencer;
  localparam int N_VEC = 16;
  localparam int N_TMPL = 26;
  localparam int W = 8;
  localparam int N_ENT = N_VEC * N_TMPL;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_in_valid = 1'b0, i_in_sof = 1'b0;
  logic [W-1:0] i_in_x = '0, i_in_y = '0;
  logic         i_lib_we = 1'b0;
  logic [8:0]   i_lib_addr = '0;
  logic [W-1:0] i_lib_x = '0, i_lib_y = '0;
  logic         o_valid, o_busy, o_drop;
  logic [8:0]   o_index;
  logic [W-1:0] o_vector_x, o_vector_y, o_lib_x, o_lib_y;

  gesture_vector_sequencer #(.N_VEC(N_VEC), .N_TMPL(N_TMPL), .W(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_in_valid(i_in_valid), .i_in_sof(i_in_sof), .i_in_x(i_in_x), .i_in_y(i_in_y),
    .i_lib_we(i_lib_we), .i_lib_addr(i_lib_addr), .i_lib_x(i_lib_x), .i_lib_y(i_lib_y),
    .o_valid(o_valid), .o_index(o_index), .o_vector_x(o_vector_x), .o_vector_y(o_vector_y),
    .o_lib_x(o_lib_x), .o_lib_y(o_lib_y), .o_busy(o_busy), .o_drop(o_drop)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // model: library contents and up to four frames
  logic [W-1:0] lib_x [N_ENT];
  logic [W-1:0] lib_y [N_ENT];
  logic [W-1:0] fx [4][N_VEC];
  logic [W-1:0] fy [4][N_VEC];

  // scoreboard: expected beats {index, vx, vy, lx, ly} and observed beats
  logic [40:0] exp_q[$];
  logic [40:0] obs_q[$];
  int          obs_cyc_q[$];
  int          drop_q[$];

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      obs_q.push_back({o_index, o_vector_x, o_vector_y, o_lib_x, o_lib_y});
      obs_cyc_q.push_back(cyc);
    end
    if (o_drop === 1'b1) drop_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic lib_write(input int a, input logic [W-1:0] x, input logic [W-1:0] y);
    i_lib_we = 1'b1; i_lib_addr = 9'(a); i_lib_x = x; i_lib_y = y;
    tick();
    i_lib_we = 1'b0;
    if (a < N_ENT) begin lib_x[a] = x; lib_y[a] = y; end
  endtask

  task automatic send_beat(input logic sof, input logic [W-1:0] x, input logic [W-1:0] y);
    i_in_valid = 1'b1; i_in_sof = sof; i_in_x = x; i_in_y = y;
    tick();
    i_in_valid = 1'b0; i_in_sof = 1'b0;
  endtask

  task automatic rand_frame(input int k);
    for (int s = 0; s < N_VEC; s++) begin
      fx[k][s] = W'($urandom_range(0, 255));
      fy[k][s] = W'($urandom_range(0, 255));
    end
  endtask

  task automatic send_frame(input int k, output int last);
    last = 0;
    for (int s = 0; s < N_VEC; s++) begin
      if (s == N_VEC - 1) last = cyc;
      send_beat(s == 0, fx[k][s], fy[k][s]);
    end
  endtask

  // Every beat i of a burst pairs frame slot i mod N_VEC with library entry i.
  task automatic push_expected(input int k);
    for (int i = 0; i < N_ENT; i++)
      exp_q.push_back({9'(i), fx[k][i % N_VEC], fy[k][i % N_VEC], lib_x[i], lib_y[i]});
  endtask

  task automatic take_burst(output bit got, output int start, output int bad,
                            output logic [40:0] first_got, output logic [40:0] first_exp);
    int waited;
    int c;
    logic [40:0] g, e;
    waited = 0; got = 1'b0; start = -1; bad = 0; first_got = '0; first_exp = '0;
    while (obs_q.size() < N_ENT && waited < 3000) begin tick(); waited++; end
    if (obs_q.size() < N_ENT) begin
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
      return;
    end
    got = 1'b1;
    start = obs_cyc_q[0];
    for (int i = 0; i < N_ENT; i++) begin
      g = obs_q.pop_front();
      c = obs_cyc_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 41'h0;
      if (g !== e || c !== start + i) begin
        if (bad == 0) begin first_got = g; first_exp = e; end
        bad++;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({o_valid, o_busy, o_drop} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 000", {o_valid, o_busy, o_drop});
    end
    n_checks++;
    if ({o_index, o_vector_x, o_vector_y, o_lib_x, o_lib_y} !== 41'h0) begin
      n_errors++; $display("FAIL reset_data: got %h expected 0", {o_index, o_vector_x, o_vector_y, o_lib_x, o_lib_y});
    end
    i_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send_beat(1'b0, W'($urandom_range(0, 255)), W'(i));
    repeat (6) tick();
    n_checks++;
    if (obs_q.size() !== 0 || o_busy !== 1'b0) begin
      n_errors++; $display("FAIL pre_sof_ignored: got beats=%0d busy=%b expected 0 0", obs_q.size(), o_busy);
    end
  endtask

  task automatic load_library();
    for (int a = 0; a < N_ENT; a++) lib_write(a, W'(a % 128), W'(-(a % 128)));
  endtask

  task automatic test_basic();
    int t, st, bad; bit got; logic [40:0] fg, fe;
    for (int s = 0; s < N_VEC; s++) begin fx[0][s] = W'(s + 1); fy[0][s] = W'(s + 1); end
    send_frame(0, t);
    push_expected(0);
    take_burst(got, st, bad, fg, fe);
    n_checks++;
    if (got !== 1'b1) begin n_errors++; $display("FAIL basic_burst_arrived: got none expected %0d beats", N_ENT); end
    n_checks++;
    if (st !== t + 2) begin n_errors++; $display("FAIL basic_latency: got start %0d expected %0d", st, t + 2); end
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL basic_contents: %0d bad beats, got %h expected %h", bad, fg, fe); end
    n_checks++;
    if ({o_valid, o_busy, o_index, o_lib_x, o_lib_y} !== {2'b00, 9'd415, lib_x[415], lib_y[415]}) begin
      n_errors++; $display("FAIL basic_hold: got v=%b b=%b idx=%0d lx=%h ly=%h expected 0 0 415 %h %h",
                           o_valid, o_busy, o_index, o_lib_x, o_lib_y, lib_x[415], lib_y[415]);
    end
    repeat (4) tick();
    n_checks++;
    if (obs_q.size() !== 0) begin n_errors++; $display("FAIL basic_idle_after: got %0d beats expected 0", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    int ta, tb, sa, sb, bad_a, bad_b; bit ga, gb; logic [40:0] fg, fe, fg2, fe2;
    drop_q.delete();
    rand_frame(1); rand_frame(2);
    send_frame(1, ta); push_expected(1);
    repeat (40) tick();
    send_frame(2, tb); push_expected(2);
    take_burst(ga, sa, bad_a, fg, fe);
    take_burst(gb, sb, bad_b, fg2, fe2);
    n_checks++;
    if (ga !== 1'b1 || sa !== ta + 2 || bad_a !== 0) begin
      n_errors++; $display("FAIL b2b_first: got arrived=%b start=%0d bad=%0d (%h) expected 1 %0d 0 (%h)", ga, sa, bad_a, fg, ta + 2, fe);
    end
    n_checks++;
    if (gb !== 1'b1 || sb !== sa + N_ENT - 1 + 3) begin
      n_errors++; $display("FAIL b2b_restart: got arrived=%b start=%0d expected 1 %0d", gb, sb, sa + N_ENT - 1 + 3);
    end
    n_checks++;
    if (bad_b !== 0) begin n_errors++; $display("FAIL b2b_second: %0d bad beats, got %h expected %h", bad_b, fg2, fe2); end
    n_checks++;
    if (drop_q.size() !== 0) begin n_errors++; $display("FAIL b2b_no_drop: got %0d drops expected 0", drop_q.size()); end
  endtask

  task automatic test_overflow();
    int ta, tb, tc, sa, sb, bad_a, bad_b; bit ga, gb; logic [40:0] fg, fe, fg2, fe2;
    repeat (5) tick();
    drop_q.delete();
    rand_frame(1); rand_frame(2); rand_frame(3);
    send_frame(1, ta); push_expected(1);
    repeat (20) tick();
    send_frame(2, tb); push_expected(2);
    repeat (10) tick();
    send_frame(3, tc);
    take_burst(ga, sa, bad_a, fg, fe);
    take_burst(gb, sb, bad_b, fg2, fe2);
    n_checks++;
    if (ga !== 1'b1 || sa !== ta + 2 || bad_a !== 0) begin
      n_errors++; $display("FAIL ovf_a: got arrived=%b start=%0d bad=%0d (%h) expected 1 %0d 0 (%h)", ga, sa, bad_a, fg, ta + 2, fe);
    end
    n_checks++;
    if (gb !== 1'b1 || sb !== sa + N_ENT + 2 || bad_b !== 0) begin
      n_errors++; $display("FAIL ovf_b: got arrived=%b start=%0d bad=%0d (%h) expected 1 %0d 0 (%h)", gb, sb, bad_b, fg2, sa + N_ENT + 2, fe2);
    end
    n_checks++;
    if (drop_q.size() !== 1) begin n_errors++; $display("FAIL ovf_drop_count: got %0d expected 1", drop_q.size()); end
    else begin
      n_checks++;
      if (drop_q[0] !== tc - (N_VEC - 1) + 1) begin
        n_errors++; $display("FAIL ovf_drop_cycle: got %0d expected %0d", drop_q[0], tc - (N_VEC - 1) + 1);
      end
    end
    repeat (20) tick();
    n_checks++;
    if (obs_q.size() !== 0 || o_busy !== 1'b0) begin
      n_errors++; $display("FAIL ovf_c_discarded: got beats=%0d busy=%b expected 0 0", obs_q.size(), o_busy);
    end
  endtask

  task automatic test_restart();
    int t, st, bad; bit got; logic [40:0] fg, fe;
    drop_q.delete();
    for (int i = 0; i < 3; i++) send_beat(1'b0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    send_beat(1'b1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    for (int i = 1; i < 9; i++) send_beat(1'b0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    rand_frame(1);
    send_frame(1, t); push_expected(1);
    take_burst(got, st, bad, fg, fe);
    n_checks++;
    if (got !== 1'b1 || st !== t + 2) begin
      n_errors++; $display("FAIL restart_start: got arrived=%b start=%0d expected 1 %0d", got, st, t + 2);
    end
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL restart_contents: %0d bad beats, got %h expected %h", bad, fg, fe); end
    repeat (20) tick();
    n_checks++;
    if (obs_q.size() !== 0 || drop_q.size() !== 0) begin
      n_errors++; $display("FAIL restart_single: got beats=%0d drops=%0d expected 0 0", obs_q.size(), drop_q.size());
    end
  endtask

  task automatic test_lib_collision();
    int t, st, bad; bit got; logic [40:0] fg, fe;
    rand_frame(2);
    send_frame(2, t); push_expected(2);
    while (cyc < t + 37) tick();
    i_lib_we = 1'b1; i_lib_addr = 9'd37; i_lib_x = 8'h7F; i_lib_y = 8'h80;
    tick();
    i_lib_we = 1'b0;
    lib_x[37] = 8'h7F; lib_y[37] = 8'h80;
    lib_write(416, 8'h55, 8'h66);
    take_burst(got, st, bad, fg, fe);
    n_checks++;
    if (got !== 1'b1 || bad !== 0) begin
      n_errors++; $display("FAIL collision_old_data: got arrived=%b bad=%0d (%h) expected 1 0 (%h)", got, bad, fg, fe);
    end
    repeat (5) tick();
    rand_frame(3);
    send_frame(3, t); push_expected(3);
    take_burst(got, st, bad, fg, fe);
    n_checks++;
    if (got !== 1'b1 || st !== t + 2 || bad !== 0) begin
      n_errors++; $display("FAIL collision_new_data: got arrived=%b start=%0d bad=%0d (%h) expected 1 %0d 0 (%h)", got, st, bad, fg, t + 2, fe);
    end
  endtask

  task automatic test_reset_midstream();
    int t, st, bad; bit got; logic [40:0] fg, fe;
    repeat (5) tick();
    rand_frame(0);
    send_frame(0, t);
    while (cyc < t + 202) tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_index !== 9'd200) begin
      n_errors++; $display("FAIL mid_index: got v=%b idx=%0d expected 1 200", o_valid, o_index);
    end
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_busy, o_drop, o_index, o_vector_x, o_vector_y, o_lib_x, o_lib_y} !== 44'h0) begin
      n_errors++; $display("FAIL mid_reset_outputs: got v=%b b=%b idx=%0d expected all 0", o_valid, o_busy, o_index);
    end
    obs_q.delete(); obs_cyc_q.delete();
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (o_busy !== 1'b0 || obs_q.size() !== 0) begin
      n_errors++; $display("FAIL mid_after_release: got busy=%b beats=%0d expected 0 0", o_busy, obs_q.size());
    end
    rand_frame(1);
    send_frame(1, t); push_expected(1);
    take_burst(got, st, bad, fg, fe);
    n_checks++;
    if (got !== 1'b1 || st !== t + 2 || bad !== 0) begin
      n_errors++; $display("FAIL mid_new_frame: got arrived=%b start=%0d bad=%0d (%h) expected 1 %0d 0 (%h)", got, st, bad, fg, t + 2, fe);
    end
  endtask

  initial begin
    test_reset();
    load_library();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_restart();
    test_lib_collision();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
